// File: rtl/gfm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gfm_pkg : shared types and constants for glitch-free mux control     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gfm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VERIFY = 2'd2,
    REVERT = 2'd3
  } gfm_state_e;

  localparam logic GFM_SEL_CLK1 = 1'b1;
  localparam logic GFM_SEL_CLK2 = 1'b0;

  // One counter width serves the settle, edge and timeout counters.
  function automatic int gfm_cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gfm_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gfm_edge_sync : 2-flop synchronizer plus rising-edge detect          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gfm_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       dly_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b00;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      dly_q  <= sync_q[1];
    end
  end

  assign rise_o = sync_q[1] & ~dly_q;

endmodule
`default_nettype wire

// File: rtl/gfm_switch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gfm_switch_ctrl : drives mux select and confirms each clock switch   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gfm_switch_ctrl
  import gfm_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_EDGES    = 4,
  parameter int TIMEOUT       = 256
) (
  input  logic clk,
  input  logic rstn,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic mon_clk,
  output logic select,
  output logic active_sel,
  output logic busy,
  output logic done_pulse,
  output logic fail_pulse,
  output logic fault,
  output logic clk_lost
);

  localparam int            CW          = gfm_cnt_width(SETTLE_CYCLES, TIMEOUT);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_MAX     = CW'(TIMEOUT);
  localparam logic [CW-1:0] EDGE_MAX    = CW'(LOCK_EDGES);
  localparam logic [CW-1:0] ONE         = CW'(1);

  gfm_state_e    state_q, state_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [CW-1:0] edge_q, edge_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          select_q, select_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic          fault_q, fault_d;
  logic          lost_q, lost_d;
  logic          ready_q, busy_q;

  logic          mon_rise;
  logic          accept;
  logic [CW-1:0] edge_inc;
  logic [CW-1:0] tmo_inc;

  gfm_edge_sync u_mon_sync (
    .clk    (clk),
    .rstn   (rstn),
    .d_i    (mon_clk),
    .rise_o (mon_rise)
  );

  assign accept   = req_valid & ready_q;
  assign edge_inc = (mon_rise && (edge_q != EDGE_MAX)) ? edge_q + ONE : edge_q;
  assign tmo_inc  = (tmo_q != TMO_MAX) ? tmo_q + ONE : tmo_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    edge_d   = edge_q;
    tmo_d    = tmo_q;
    select_d = select_q;
    active_d = active_q;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    fault_d  = fault_q;
    lost_d   = lost_q;

    case (state_q)
      IDLE: begin
        // Idle reuses the timeout counter as the loss-of-clock monitor.
        if (mon_rise) begin
          tmo_d  = '0;
          lost_d = 1'b0;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_MAX) begin
            lost_d  = 1'b1;
            fault_d = 1'b1;
          end
        end
        if (accept) begin
          if (req_sel != active_q) begin
            state_d  = SETTLE;
            select_d = req_sel;
            settle_d = '0;
            edge_d   = '0;
            tmo_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SETTLE: begin
        edge_d = '0;
        tmo_d  = '0;
        if (settle_q == SETTLE_LAST) begin
          state_d  = VERIFY;
          settle_d = '0;
        end else begin
          settle_d = settle_q + ONE;
        end
      end

      VERIFY: begin
        edge_d = edge_inc;
        tmo_d  = tmo_inc;
        // Lock is tested first so a coincident final edge beats the timeout.
        if (edge_inc == EDGE_MAX) begin
          state_d  = IDLE;
          active_d = select_q;
          done_d   = 1'b1;
          fault_d  = 1'b0;
          lost_d   = 1'b0;
          edge_d   = '0;
          tmo_d    = '0;
        end else if (tmo_inc == TMO_MAX) begin
          state_d  = REVERT;
          select_d = active_q;
          fail_d   = 1'b1;
          fault_d  = 1'b1;
          settle_d = '0;
        end
      end

      REVERT: begin
        edge_d = '0;
        tmo_d  = '0;
        if (settle_q == SETTLE_LAST) begin
          state_d  = IDLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      settle_q <= '0;
      edge_q   <= '0;
      tmo_q    <= '0;
      select_q <= GFM_SEL_CLK2;
      active_q <= GFM_SEL_CLK2;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      fault_q  <= 1'b0;
      lost_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      edge_q   <= edge_d;
      tmo_q    <= tmo_d;
      select_q <= select_d;
      active_q <= active_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      fault_q  <= fault_d;
      lost_q   <= lost_d;
      ready_q  <= (state_d == IDLE);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign select     = select_q;
  assign active_sel = active_q;
  assign done_pulse = done_q;
  assign fail_pulse = fail_q;
  assign fault      = fault_q;
  assign clk_lost   = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_gfm_switch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_gfm_switch_ctrl : randomized self-checking bench for the switch    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gfm_switch_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic mon_clk = 1'b0;
  logic req_ready, select, active_sel, busy, done_pulse, fail_pulse, fault, clk_lost;

  int n_total = 0;
  int n_pass  = 0;
  int mon_half = 50;
  bit mon_en = 1'b1;

  // Model of the controller's externally visible state.
  bit exp_active = 1'b0;
  bit exp_fault  = 1'b0;

  gfm_switch_ctrl #(
    .SETTLE_CYCLES (16),
    .LOCK_EDGES    (4),
    .TIMEOUT       (256)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .mon_clk    (mon_clk),
    .select     (select),
    .active_sel (active_sel),
    .busy       (busy),
    .done_pulse (done_pulse),
    .fail_pulse (fail_pulse),
    .fault      (fault),
    .clk_lost   (clk_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #3;
    forever begin
      if (mon_en) begin
        #(mon_half);
        mon_clk = ~mon_clk;
      end else begin
        mon_clk = 1'b0;
        #7;
      end
    end
  end

  // A switch is accepted, settles for 16 cycles (k=1..16), verifies from k=17,
  // and confirms after four monitor periods or reverts at k=17+256.
  task automatic run_req(input bit sel, input bit ok, input bit hold, input bit nsel);
    int k;
    int p;
    int lo;
    int hi;
    bit sw;
    bit got_done;
    bit got_fail;
    bit excl_bad;
    p  = (2 * mon_half + 9) / 10;
    lo = 17 + (6 * mon_half) / 10 - 1;
    hi = 17 + 4 * p + 6;
    sw = (sel != exp_active);
    req_valid = 1'b1;
    req_sel   = sel;
    k = 0;
    while (req_ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (req_ready !== 1'b1) begin
      $display("FAIL accept_wait: req_ready=%b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    n_pass++;
    @(negedge clk);
    if (hold) req_sel = nsel;
    else req_valid = 1'b0;
    n_total++;
    if (select !== (sw ? sel : exp_active) || busy !== sw)
      $display("FAIL launch: select=%b busy=%b, required select=%b busy=%b",
               select, busy, sw ? sel : exp_active, sw);
    else n_pass++;
    k = 1;
    got_done = 1'b0;
    got_fail = 1'b0;
    excl_bad = 1'b0;
    forever begin
      if (req_ready === 1'b1 && busy === 1'b1) excl_bad = 1'b1;
      if (done_pulse === 1'b1) begin got_done = 1'b1; break; end
      if (fail_pulse === 1'b1) begin got_fail = 1'b1; break; end
      if (k >= 400) break;
      @(negedge clk);
      k++;
    end
    n_total++;
    if (excl_bad) $display("FAIL ready_busy: both high together, required exclusive");
    else n_pass++;
    if (!sw) begin
      n_total++;
      if (!got_done || k != 1 || active_sel !== exp_active || fault !== exp_fault)
        $display("FAIL same_sel: done_k=%0d seen=%b active=%b fault=%b, required k=1 active=%b fault=%b",
                 k, got_done, active_sel, fault, exp_active, exp_fault);
      else n_pass++;
    end else if (ok) begin
      n_total++;
      if (!got_done || k < lo || k > hi)
        $display("FAIL switch_latency: done_k=%0d seen=%b, required %0d..%0d", k, got_done, lo, hi);
      else n_pass++;
      n_total++;
      if (active_sel !== sel || select !== sel || fault !== 1'b0 || clk_lost !== 1'b0 ||
          req_ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL switch_result: act=%b sel=%b fault=%b lost=%b rdy=%b busy=%b, required act=sel=%b 0 0 1 0",
                 active_sel, select, fault, clk_lost, req_ready, busy, sel);
      else n_pass++;
      exp_active = sel;
      exp_fault  = 1'b0;
    end else begin
      n_total++;
      if (!got_fail || k != 273)
        $display("FAIL fail_timing: fail_k=%0d seen=%b, required 273", k, got_fail);
      else n_pass++;
      n_total++;
      if (select !== exp_active || active_sel !== exp_active || fault !== 1'b1 ||
          busy !== 1'b1 || req_ready !== 1'b0)
        $display("FAIL revert_state: sel=%b act=%b fault=%b busy=%b rdy=%b, required sel=act=%b 1 1 0",
                 select, active_sel, fault, busy, req_ready, exp_active);
      else n_pass++;
      exp_fault = 1'b1;
      repeat (15) @(negedge clk);
      n_total++;
      if (req_ready !== 1'b0 || busy !== 1'b1 || fail_pulse !== 1'b0)
        $display("FAIL revert_hold: rdy=%b busy=%b fail=%b, required 0 1 0", req_ready, busy, fail_pulse);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (req_ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL revert_exit: rdy=%b busy=%b, required 1 0", req_ready, busy);
      else n_pass++;
    end
    if (!hold && got_done) begin
      @(negedge clk);
      n_total++;
      if (done_pulse !== 1'b0) $display("FAIL done_width: done_pulse=%b, required 0", done_pulse);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({select, active_sel, busy, req_ready, done_pulse, fail_pulse, fault, clk_lost} !== 8'b0)
      $display("FAIL reset_values: outs=%b, required 00000000",
               {select, active_sel, busy, req_ready, done_pulse, fail_pulse, fault, clk_lost});
    else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || select !== 1'b0 || active_sel !== 1'b0 ||
        done_pulse !== 1'b0 || fail_pulse !== 1'b0)
      $display("FAIL reset_release: rdy=%b busy=%b sel=%b act=%b done=%b fail=%b, required 1 0 0 0 0 0",
               req_ready, busy, select, active_sel, done_pulse, fail_pulse);
    else n_pass++;
    exp_active = 1'b0;
    exp_fault  = 1'b0;
  endtask

  task automatic test_same_sel();
    run_req(exp_active, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_switch_random();
    bit s;
    run_req(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      mon_half = $urandom_range(25, 60);
      s = 1'($urandom_range(0, 1));
      run_req(s, 1'b1, 1'b0, 1'b0);
    end
    mon_half = 50;
  endtask

  task automatic test_timeout();
    mon_en = 1'b0;
    run_req(~exp_active, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    run_req(~exp_active, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_clk_lost();
    int k;
    int p;
    bit s0;
    p  = (2 * mon_half + 9) / 10;
    s0 = exp_active;
    mon_en = 1'b0;
    k = 0;
    while (clk_lost !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (clk_lost !== 1'b1 || k < 256 - p - 2 || k > 256 + p + 6)
      $display("FAIL clk_lost_timing: lost=%b at k=%0d, required 1 at %0d..%0d",
               clk_lost, k, 256 - p - 2, 256 + p + 6);
    else n_pass++;
    n_total++;
    if (fault !== 1'b1 || select !== s0 || active_sel !== s0 || req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL clk_lost_state: fault=%b sel=%b act=%b rdy=%b busy=%b, required 1 %b %b 1 0",
               fault, select, active_sel, req_ready, busy, s0, s0);
    else n_pass++;
    exp_fault = 1'b1;
    mon_en = 1'b1;
    k = 0;
    while (clk_lost !== 1'b0 && k < 3 * p + 10) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (clk_lost !== 1'b0) $display("FAIL clk_lost_clear: lost=%b, required 0", clk_lost);
    else n_pass++;
    n_total++;
    if (fault !== 1'b1) $display("FAIL fault_sticky: fault=%b, required 1", fault);
    else n_pass++;
    run_req(exp_active, 1'b1, 1'b0, 1'b0);
    run_req(~exp_active, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int k;
    if (exp_active) run_req(1'b0, 1'b1, 1'b0, 1'b0);
    req_valid = 1'b1;
    req_sel   = 1'b1;
    k = 0;
    while (req_ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || select !== 1'b1)
      $display("FAIL midreset_pre: busy=%b sel=%b, required 1 1", busy, select);
    else n_pass++;
    rstn = 1'b0;
    #1;
    n_total++;
    if ({select, active_sel, busy, req_ready, done_pulse, fail_pulse, fault, clk_lost} !== 8'b0)
      $display("FAIL midreset_outputs: outs=%b, required 00000000",
               {select, active_sel, busy, req_ready, done_pulse, fail_pulse, fault, clk_lost});
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    exp_active = 1'b0;
    exp_fault  = 1'b0;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || select !== 1'b0)
      $display("FAIL midreset_release: rdy=%b busy=%b sel=%b, required 1 0 0", req_ready, busy, select);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit a;
    a = ~exp_active;
    run_req(a, 1'b1, 1'b1, ~a);
    run_req(~a, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_same_sel();
    test_switch_random();
    test_same_sel();
    test_timeout();
    test_clk_lost();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
